inst_fetch_unit: RTL and testbench

Fetch stage directly upstream of the register-file/ALU datapath. It drives the 32-bit instruction word that the datapath decodes. It holds the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency. Fetched words are buffered in a small prefetch FIFO and delivered with a valid/ready handshake. It supports redirect (jump/branch) with flush, and halts on a reserved halt word.

---
 rtl/inst_fetch_unit_pkg.sv | 18 +
 rtl/inst_fetch_unit_fetch_fifo.sv | 52 +++++
 rtl/inst_fetch_unit.sv | 107 ++++++++++
 tb/tb_inst_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Prefetch buffer: power-of-2 depth ring with synchronous flush; head is zero when empty.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  assign w_do_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem reads, prefetch FIFO, redirect/flush and halt detection.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter  int          ADDR_W     = 8,
  parameter  int          FIFO_DEPTH = 4,
  parameter  logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter  logic [31:0] HALT_WORD  = HALT_WORD_DEF,
  localparam int          CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              halted,
  output logic [CW-1:0]     fifo_count
);

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, r_issue_pc, w_redir_pc;
  logic         r_inflight;
  logic         w_resp, w_halt_hit, w_push, w_issue;
  logic [CW-1:0] w_occ;
  fetch_entry_t w_push_entry, w_head;

  assign w_redir_pc = redirect_pc & ~32'h3;

  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign w_resp     = r_inflight & ~redirect_valid;
  assign w_halt_hit = w_resp & (imem_rdata == HALT_WORD);
  assign w_push     = w_resp & ~w_halt_hit;
  assign w_occ      = fifo_count + CW'(r_inflight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect_valid) begin
      w_next_state = en ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = w_halt_hit ? ST_HALT : (en ? ST_RUN : ST_IDLE);
        ST_RUN:  w_next_state = w_halt_hit ? ST_HALT : (en ? ST_RUN : ST_IDLE);
        ST_HALT: w_next_state = en ? ST_HALT : ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Suppressing issue on a halt hit keeps the PC frozen just past the halt word.
  always_comb begin
    w_issue = (r_state == ST_RUN) & en & ~redirect_valid & ~w_halt_hit &
              (w_occ < CW'(FIFO_DEPTH));
    imem_rd = w_issue;
    halted  = (r_state == ST_HALT);
  end

  assign imem_addr = r_pc[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_pc <= w_redir_pc;
      end else if (w_issue) begin
        r_pc       <= r_pc + PC_INC;
        r_issue_pc <= r_pc;
      end
    end
  end

  assign w_push_entry = '{inst: imem_rdata, pc: r_issue_pc};

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (inst_valid & inst_ready),
    .i_flush (redirect_valid),
    .o_count (fifo_count),
    .o_head  (w_head)
  );

  assign inst_valid = (fifo_count != '0);
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 256-word synchronous memory model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, en, redirect_valid, inst_ready;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, halted;
  logic [2:0]  fifo_count;

  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .halted(halted), .fifo_count(fifo_count)
  );

  // Occupancy must never exceed depth (a push into a full buffer would show as count > 4).
  always @(negedge clk) if (rst_n) begin
    checks++;
    assert (fifo_count <= 3'd4) else begin
      errors++;
      $error("FAIL fifo_overflow: got %0d expected <= 4", fifo_count);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic head(input int w, input logic [31:0] pc);
    chk("inst_valid", 32'(inst_valid), 32'd1);
    chk("inst", inst, 32'h1000_0000 + 32'(w));
    chk("inst_pc", inst_pc, pc);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    repeat (3) tick;

    // reset state
    chk("rst_imem_rd", 32'(imem_rd), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(fifo_count), 0);

    // streaming: first issue, 2-cycle latency, one word per cycle
    rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1; #1;
    chk("idle_no_rd", 32'(imem_rd), 0);
    tick;
    chk("first_rd", 32'(imem_rd), 1);
    chk("first_addr", 32'(imem_addr), 0);
    chk("lat_v0", 32'(inst_valid), 0);
    tick;
    chk("lat_v1", 32'(inst_valid), 0);
    chk("b2b_addr", 32'(imem_addr), 1);
    tick;
    for (int i = 0; i < 5; i++) begin head(i, 32'(4 * i)); tick; end

    // backpressure: saturate at 4, then drain without loss or duplication
    inst_ready = 1'b0;
    repeat (10) tick;
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_no_rd", 32'(imem_rd), 0);
    head(5, 32'h14);
    inst_ready = 1'b1; #1;
    for (int i = 5; i < 13; i++) begin head(i, 32'(4 * i)); tick; end

    // redirect with 3 buffered, one inflight, and a pop in the same cycle
    inst_ready = 1'b0;
    tick;
    chk("pre_redir_count", 32'(fifo_count), 3);
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1; #1;
    chk("redir_no_rd", 32'(imem_rd), 0);
    tick;
    redirect_valid = 1'b0; #1;
    chk("flush_count", 32'(fifo_count), 0);
    chk("flush_valid", 32'(inst_valid), 0);
    chk("redir_rd", 32'(imem_rd), 1);
    chk("redir_addr", 32'(imem_addr), 16);
    tick;
    chk("no_stale", 32'(inst_valid), 0);
    tick; head(16, 32'h40);
    tick; head(17, 32'h44);

    // halt word at index 5
    mem[5] = 32'hFFFF_FFFF;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick;
    redirect_valid = 1'b0; #1;
    chk("h_addr0", 32'(imem_addr), 0);
    tick; tick;
    for (int i = 0; i < 5; i++) begin head(i, 32'(4 * i)); tick; end
    chk("halted", 32'(halted), 1);
    chk("halt_empty", 32'(inst_valid), 0);
    chk("halt_no_rd", 32'(imem_rd), 0);
    repeat (3) tick;
    chk("halt_still_no_rd", 32'(imem_rd), 0);
    chk("halt_held", 32'(halted), 1);

    // redirect out of HALT resumes from word 0
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick;
    redirect_valid = 1'b0; #1;
    chk("resume_halted", 32'(halted), 0);
    chk("resume_rd", 32'(imem_rd), 1);
    chk("resume_addr", 32'(imem_addr), 0);
    tick; tick;
    for (int i = 0; i < 5; i++) begin head(i, 32'(4 * i)); tick; end
    chk("halted_again", 32'(halted), 1);

    // en low then high resumes after the halt word
    en = 1'b0;
    tick;
    chk("halt_to_idle", 32'(halted), 0);
    en = 1'b1; inst_ready = 1'b0; #1;
    chk("idle_rd", 32'(imem_rd), 0);
    tick;
    chk("en_resume_rd", 32'(imem_rd), 1);
    chk("en_resume_addr", 32'(imem_addr), 6);
    repeat (3) tick;
    chk("pre_rst_count", 32'(fifo_count), 2);

    // asynchronous reset mid-stream
    #2; rst_n = 1'b0; #1;
    chk("arst_valid", 32'(inst_valid), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_rd", 32'(imem_rd), 0);
    chk("arst_inst", inst, 0);
    chk("arst_inst_pc", inst_pc, 0);
    chk("arst_halted", 32'(halted), 0);
    mem[5] = 32'h1000_0005;
    #2; rst_n = 1'b1; inst_ready = 1'b1;
    tick;
    chk("restart_rd", 32'(imem_rd), 1);
    chk("restart_addr", 32'(imem_addr), 0);

    // redirect on a returning response, low bits ignored, address wrap
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h3FF;
    tick;
    redirect_valid = 1'b0; #1;
    chk("drop_count", 32'(fifo_count), 0);
    chk("wrap_rd", 32'(imem_rd), 1);
    chk("wrap_addr255", 32'(imem_addr), 255);
    tick;
    chk("wrap_addr0", 32'(imem_addr), 0);
    chk("drop_valid", 32'(inst_valid), 0);
    tick; head(255, 32'h3FC);
    tick; head(0, 32'h400);
    tick; head(1, 32'h404);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
